// File: rtl/dsec_pkg.sv
// Shared types and constants for the dsec ingress front-end: error codes,
// sequencer state encoding and the error code width.
package dsec_pkg;
  localparam int ERR_W = 8;
  typedef logic [ERR_W-1:0] err_code_t;

  localparam err_code_t ERR_NONE       = 8'h00;
  localparam err_code_t ERR_NO_KEY     = 8'h01;
  localparam err_code_t ERR_REKEY_BUSY = 8'h02;
  localparam err_code_t ERR_OVERFLOW   = 8'h03;

  typedef enum logic [1:0] {
    ST_NOKEY   = 2'd0,
    ST_KEYLOAD = 2'd1,
    ST_STREAM  = 2'd2
  } state_t;
endpackage

// File: rtl/dsec_ingress_if.sv
// Host beat port, compressor handshake and key/error status of the ingress block.
interface dsec_ingress_if
  import dsec_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int NUM_KEYS = 3
);
  logic [DATA_W-1:0]          data_in;
  logic                       in_valid;
  logic                       key_config;
  logic                       rdy;
  logic                       err_clr;
  logic                       comp_rdy;
  logic                       comp_valid;
  logic [DATA_W-1:0]          comp_data;
  logic [NUM_KEYS*DATA_W-1:0] key_bus;
  logic                       keys_valid;
  logic                       error;
  err_code_t                  error_code;

  modport master (
    output data_in, in_valid, key_config, err_clr, comp_rdy,
    input  rdy, comp_valid, comp_data, key_bus, keys_valid, error, error_code
  );

  modport slave (
    input  data_in, in_valid, key_config, err_clr, comp_rdy,
    output rdy, comp_valid, comp_data, key_bus, keys_valid, error, error_code
  );
endinterface

// File: rtl/dsec_sync_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry one wrap bit so
// full and empty are told apart without a separate counter.
module dsec_sync_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end
endmodule

// File: rtl/dsec_ingress.sv
// Ingress front-end: sorts host beats into key-bank loads or buffered data
// words, and keeps the first host protocol violation as a sticky error code.
module dsec_ingress
  import dsec_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int NUM_KEYS   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  dsec_ingress_if.slave bus
);
  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  // A single-key bank completes on its first beat, so a rekey never leaves STREAM.
  localparam state_t REKEY_STATE = (NUM_KEYS == 1) ? ST_STREAM : ST_KEYLOAD;

  state_t                     r_state;
  state_t                     w_next_state;
  logic [IDX_W-1:0]           r_idx;
  logic [IDX_W-1:0]           w_idx_next;
  logic [IDX_W-1:0]           w_key_sel;
  logic [DATA_W-1:0]          r_keys [NUM_KEYS];
  logic [NUM_KEYS*DATA_W-1:0] w_key_bus;
  logic                       r_keys_valid;
  logic                       r_error;
  err_code_t                  r_error_code;
  err_code_t                  w_err_code;
  logic                       w_rdy;
  logic                       w_key_we;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_err_set;
  logic                       w_full;
  logic                       w_empty;
  logic [DATA_W-1:0]          w_head;

  dsec_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (bus.data_in),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_NOKEY;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_NOKEY:   w_next_state = (bus.in_valid && bus.key_config) ? REKEY_STATE : ST_NOKEY;
      ST_KEYLOAD: w_next_state = (bus.in_valid && (r_idx == LAST_IDX)) ? ST_STREAM : ST_KEYLOAD;
      ST_STREAM:  w_next_state = (bus.in_valid && !w_full && bus.key_config && w_empty) ? REKEY_STATE : ST_STREAM;
      default:    w_next_state = ST_NOKEY;
    endcase
  end

  always_comb begin
    w_rdy      = 1'b0;
    w_key_we   = 1'b0;
    w_key_sel  = '0;
    w_idx_next = r_idx;
    w_push     = 1'b0;
    w_err_set  = 1'b0;
    w_err_code = ERR_NONE;
    case (r_state)
      ST_NOKEY: begin
        w_rdy = 1'b1;
        if (bus.in_valid && bus.key_config) begin
          w_key_we   = 1'b1;
          w_idx_next = IDX_ONE;
        end else if (bus.in_valid) begin
          w_err_set  = 1'b1;
          w_err_code = ERR_NO_KEY;
        end else begin
          w_err_set = 1'b0;
        end
      end
      ST_KEYLOAD: begin
        w_rdy = 1'b1;
        if (bus.in_valid) begin
          w_key_we   = 1'b1;
          w_key_sel  = r_idx;
          w_idx_next = r_idx + IDX_ONE;
        end else begin
          w_key_we = 1'b0;
        end
      end
      ST_STREAM: begin
        w_rdy = !w_full;
        if (bus.in_valid && w_full) begin
          w_err_set  = 1'b1;
          w_err_code = ERR_OVERFLOW;
        end else if (bus.in_valid && bus.key_config && w_empty) begin
          w_key_we   = 1'b1;
          w_idx_next = IDX_ONE;
        end else if (bus.in_valid && bus.key_config) begin
          w_err_set  = 1'b1;
          w_err_code = ERR_REKEY_BUSY;
        end else if (bus.in_valid) begin
          w_push = 1'b1;
        end else begin
          w_push = 1'b0;
        end
      end
      default: w_rdy = 1'b0;
    endcase
  end

  // Key bank, load index and the keys_valid flag that tracks entry into STREAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_KEYS; k++) r_keys[k] <= '0;
      r_idx        <= '0;
      r_keys_valid <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (w_key_we && (w_key_sel == IDX_W'(k))) r_keys[k] <= bus.data_in;
      end
      r_idx        <= w_idx_next;
      r_keys_valid <= (w_next_state == ST_STREAM);
    end
  end

  // A new error wins over a simultaneous clear; otherwise the first one sticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_error      <= 1'b0;
      r_error_code <= ERR_NONE;
    end else if (w_err_set && (!r_error || bus.err_clr)) begin
      r_error      <= 1'b1;
      r_error_code <= w_err_code;
    end else if (bus.err_clr) begin
      r_error      <= 1'b0;
      r_error_code <= ERR_NONE;
    end
  end

  always_comb begin
    w_key_bus = '0;
    for (int k = 0; k < NUM_KEYS; k++) w_key_bus[k*DATA_W +: DATA_W] = r_keys[k];
  end

  assign w_pop          = bus.comp_rdy & ~w_empty;
  assign bus.rdy        = w_rdy & ~rst;
  assign bus.comp_valid = ~w_empty;
  assign bus.comp_data  = w_head;
  assign bus.key_bus    = w_key_bus;
  assign bus.keys_valid = r_keys_valid;
  assign bus.error      = r_error;
  assign bus.error_code = r_error_code;
endmodule
